// File: rtl/pc_fetch_sequencer_if.sv
// pc_fetch_sequencer_if: instruction-memory fetch handshake between sequencer and memory
interface pc_fetch_sequencer_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;
  modport master(output ImemReq, ImemAddr, input ImemAck, ImemData);
  modport slave(input ImemReq, ImemAddr, output ImemAck, ImemData);
endinterface

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: handshaked, fault-checked PC sequencing through fetch and branch resolve
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          TIMEOUT      = 15
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic                        Stall,
  pc_fetch_sequencer_if.master        imem,
  output logic                        InstrValid,
  output logic [31:0]                 Instr,
  output logic [31:0]                 InstrPC,
  input  logic                        ResolveValid,
  input  logic                        Branch,
  input  logic                        Zero,
  input  logic                        Jump,
  input  logic [31:0]                 Imm,
  input  logic [31:0]                 JumpTarget,
  output logic [31:0]                 PC,
  output logic                        Busy,
  output logic                        Fault,
  output logic [1:0]                  FaultCause
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT_ACK = 3'd2,
                         S_WAIT_RESOLVE = 3'd3, S_HALT = 3'd4;
  logic [2:0]    state;
  logic [CW-1:0] count;
  logic [31:0]   next_pc;
  always_comb next_pc = Jump ? JumpTarget : (Branch && Zero) ? PC + Imm : PC + 32'd4;
  assign imem.ImemReq  = state == S_WAIT_ACK;
  assign imem.ImemAddr = PC;
  assign Busy = state == S_ISSUE || state == S_WAIT_ACK || state == S_WAIT_RESOLVE;
  always_ff @(posedge Clock)
    if (Reset) begin
      state      <= S_IDLE;
      PC         <= RESET_VECTOR;
      count      <= '0;
      Instr      <= '0;
      InstrPC    <= '0;
      InstrValid <= 1'b0;
      Fault      <= 1'b0;
      FaultCause <= 2'b00;
    end else begin
      InstrValid <= 1'b0;
      case (state)
        S_IDLE: begin
          PC <= RESET_VECTOR;
          if (Start) state <= S_ISSUE;
        end
        S_ISSUE:
          if (!Stall) begin
            state <= S_WAIT_ACK;
            count <= '0;
          end
        S_WAIT_ACK:
          // an ack on the final allowed cycle beats the timeout
          if (imem.ImemAck) begin
            Instr      <= imem.ImemData;
            InstrPC    <= PC;
            InstrValid <= 1'b1;
            state      <= S_WAIT_RESOLVE;
          end else if (count == LAST) begin
            state      <= S_HALT;
            Fault      <= 1'b1;
            FaultCause <= 2'b01;
          end else count <= count + 1'b1;
        S_WAIT_RESOLVE:
          if (ResolveValid) begin
            if (|next_pc[1:0]) begin
              state      <= S_HALT;
              Fault      <= 1'b1;
              FaultCause <= 2'b10;
            end else begin
              PC    <= next_pc;
              state <= S_ISSUE;
            end
          end
        default: ;
      endcase
    end
endmodule
